ps2_kbd_intr_ctrl: RTL and testbench
====================================

Name: ps2_kbd_intr_ctrl

Overview:
- PS/2 keyboard receiver with a scan-code FIFO; it is the upstream source of the CPU's keyboard interrupt line (intr1) and its i/o read data.
- Deserialises 11-bit PS/2 frames, checks parity and stop bit, and queues each byte.
- Holds its interrupt request high while the FIFO is non-empty.
- The CPU's keyboard handler drains bytes with lw from i/o space (io_rdn low) and returns with eret.

Parameters:
- FIFO_AW, 3, log2 of FIFO depth (default 8 entries).
- SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data (minimum 2).
- TIMEOUT_CYCLES, 100000, system clocks without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from keyboard, asynchronous
- ps2_data  in  1  raw PS/2 data from keyboard, asynchronous
- io_rdn  in  1  CPU i/o read strobe, active low, held for the full lw cycle
- io_addr  in  8  CPU m_addr[7:0]; 0x00 = DATA, 0x04 = STATUS
- rd_data  out  32  combinational read data to CPU d_f_mem mux
- intr  out  1  keyboard interrupt request to CPU intr1, level

Behaviour:
- Reset: asynchronous on resetn low. Clears FIFO (count 0, pointers 0), receiver to IDLE, sticky flags 0, watchdog 0, synchronisers to 1. rd_data = 0, intr = 0. A frame in progress at reset is discarded.
- Input path: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is detected when the previous synchronised clock is 1 and the current is 0. Every sample is taken on the cycle the falling edge is detected.
- Receiver FSM (falling-edge driven):
  - IDLE: data=0 -> DATA, bit count 0. Data=1 -> stay IDLE, no error.
  - DATA: shift bits LSB first; after 8 bits -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: if data=1 and XOR(8 data bits, parity) = 1 (odd parity), push the byte. Otherwise drop it and set the sticky err flag. Return to IDLE in all cases.
- Push timing: the push takes effect on the same clock edge as the stop sample. The FIFO is non-empty and intr is high in the following cycle.
- FIFO (depth 2^FIFO_AW), circular pointers wrapping modulo depth, count is FIFO_AW+1 bits.
  - Push when full with no pop in the same cycle: byte dropped, sticky ovf set, contents unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged, including when full (no ovf).
- Reads are active only when io_rdn = 0; otherwise rd_data = 0.
  - DATA (0x00): rd_data = {24'h0, head byte}, or 0 when empty. Pop on the rising edge that ends the cycle. Pop when empty is a no-op.
  - STATUS (0x04): rd_data = {20'h0, count padded to 8 bits in [11:4], 1'b0 in [3], err in [2], ovf in [1], !empty in [0]}. err and ovf clear on the ending edge; if an error/overflow event occurs in that same cycle, set wins.
  - Any other io_addr: rd_data = 0, no side effects.
- intr = !empty, combinational from registered state. It drops in the cycle after the pop of the last byte. The CPU masks it via ie until eret.

Optional Feature:
- Macro: KBD_FRAME_TIMEOUT_EN
- Defined: a watchdog counts clocks while the FSM is not in IDLE and resets to 0 on every falling edge. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial frame is discarded, and err is set.
- Not defined: no watchdog. A lost bit desynchronises the FSM until reset or until later frames realign it.

Test Plan:
- Send frame for 0x1C (start 0, data, parity 0, stop 1) -> intr rises one cycle after stop edge; lw 0x00 returns 0x0000001C; intr = 0 in the next cycle; STATUS reads 0x00000000.
- Send 0x1C with parity forced to 1 -> no push, intr stays 0; STATUS = 0x00000004; a second STATUS read = 0x00000000.
- Send 9 bytes 0x01..0x09 with no reads (FIFO_AW = 3) -> STATUS = 0x00000083; eight DATA reads return 0x01..0x08; then intr = 0 and STATUS = 0x00000000.
- With FIFO full, the DATA pop coincides with the stop edge of a new byte 0x5A -> count stays 8, ovf stays 0; 0x5A is the last byte drained.
- Assert resetn low mid-frame after 4 data bits, release, then send 0x33 -> FIFO holds only 0x33, no err.
- KBD_FRAME_TIMEOUT_EN: send start plus 3 bits then idle for TIMEOUT_CYCLES clocks -> STATUS = 0x00000004; next full frame 0x45 is received correctly.

Source files
------------

// File: rtl/ps2_kbd_intr_ctrl_if.sv
// CPU i/o read port and keyboard interrupt line between the CPU and the PS/2 keyboard controller.
interface ps2_kbd_intr_ctrl_if;
  logic        io_rdn;
  logic [7:0]  io_addr;
  logic [31:0] rd_data;
  logic        intr;

  modport master (output io_rdn, output io_addr, input rd_data, input intr);
  modport slave  (input io_rdn, input io_addr, output rd_data, output intr);
endinterface

// File: rtl/ps2_kbd_intr_ctrl.sv
// PS/2 keyboard receiver with scan-code FIFO, level interrupt and CPU i/o read port.
// Optional frame watchdog enabled by defining KBD_FRAME_TIMEOUT_EN.
module ps2_kbd_intr_ctrl #(
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_kbd_intr_ctrl_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  if (SYNC_STAGES < 2 || FIFO_AW < 1 || FIFO_AW > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_kbd_intr_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [7:0]             mem_q [DEPTH];
  logic [7:0]             mem_d [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d, ovf_q, ovf_d;

  logic clk_s, data_s, fall;
  logic push_req, frame_err, push_ok, ovf_set, pop;
  logic empty, full, data_sel, stat_sel;
  logic [31:0] rd_data_c;

`ifdef KBD_FRAME_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Synchronisers and falling-edge detect
  always_comb begin : sync_next
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s      = clk_sync_q[SYNC_STAGES-1];
    data_s     = dat_sync_q[SYNC_STAGES-1];
    clk_prev_d = clk_s;
    fall       = clk_prev_q & ~clk_s;
  end

  // Frame receiver, advanced only on PS/2 falling edges
  always_comb begin : rx_fsm
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
`ifdef KBD_FRAME_TIMEOUT_EN
    wd_d = '0;
    if (state_q != S_IDLE && !fall) wd_d = wd_q + WD_W'(1);
`endif
    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        S_PARITY: begin
          parity_d = data_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (data_s && (^{shift_q, parity_q})) push_req = 1'b1;
          else frame_err = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef KBD_FRAME_TIMEOUT_EN
    // A stalled partial frame is abandoned rather than left to desynchronise later frames
    if (state_q != S_IDLE && !fall && wd_q == WD_W'(TIMEOUT_CYCLES)) begin
      state_d   = S_IDLE;
      wd_d      = '0;
      frame_err = 1'b1;
    end
`endif
  end

  // FIFO, sticky flags and read decode
  always_comb begin : fifo_next
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    data_sel = !bus.io_rdn && (bus.io_addr == 8'h00);
    stat_sel = !bus.io_rdn && (bus.io_addr == 8'h04);
    pop      = data_sel && !empty;
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);

    err_d = err_q;
    ovf_d = ovf_q;
    if (stat_sel) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (frame_err) err_d = 1'b1;
    if (ovf_set)   ovf_d = 1'b1;

    rd_data_c = 32'h0;
    if (data_sel && !empty) rd_data_c = {24'h0, mem_q[rd_ptr_q]};
    if (stat_sel) rd_data_c = {20'h0, 8'(count_q), 1'b0, err_q, ovf_q, !empty};
  end

  assign bus.rd_data = rd_data_c;
  assign bus.intr    = !empty;

  always_ff @(posedge clock or negedge resetn) begin : state_regs
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef KBD_FRAME_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
`ifdef KBD_FRAME_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_kbd_intr_ctrl.sv
// Scoreboard bench for ps2_kbd_intr_ctrl: stimulus queues expected CPU reads / intr probes, a monitor compares them.
module tb_ps2_kbd_intr_ctrl;
  localparam int unsigned TO = 200;

  logic clock = 1'b0;
  logic resetn, ps2_clk, ps2_data, probe;

  ps2_kbd_intr_ctrl_if bus();

  ps2_kbd_intr_ctrl #(.FIFO_AW(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          is_intr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: compares whenever a read strobe or intr probe is presented
  always @(negedge clock) begin : monitor
    exp_t        e;
    logic [31:0] act;
    if (!bus.io_rdn || probe) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_output: got rd_data=%h intr=%b, expected no transaction", bus.rd_data, bus.intr);
      end else begin
        e   = sb_q.pop_front();
        act = e.is_intr ? {31'h0, bus.intr} : bus.rd_data;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string n, input bit is_i, input logic [31:0] v);
    exp_t e;
    e.name = n; e.is_intr = is_i; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic cpu_read(input string n, input logic [7:0] a, input logic [31:0] exp);
    expect_val(n, 1'b0, exp);
    bus.io_addr = a;
    bus.io_rdn  = 1'b0;
    tick();
    bus.io_rdn  = 1'b1;
    tick();
  endtask

  task automatic check_intr(input string n, input logic v);
    expect_val(n, 1'b1, {31'h0, v});
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  // One PS/2 bit; optionally a DATA read whose ending edge is the edge that samples this bit
  task automatic ps2_bit(input logic b, input bit pop_here, input logic [31:0] pop_exp);
    ps2_data = b;
    repeat (4) tick();
    ps2_clk = 1'b0;
    if (pop_here) begin
      tick();
      tick();
      expect_val("data_pop_at_stop_edge", 1'b0, pop_exp);
      bus.io_addr = 8'h00;
      bus.io_rdn  = 1'b0;
      tick();
      bus.io_rdn  = 1'b1;
      repeat (5) tick();
    end else begin
      repeat (8) tick();
    end
    ps2_clk = 1'b1;
    repeat (8) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit pop_here, input logic [31:0] pop_exp);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, 32'h0);
    ps2_bit(par, 1'b0, 32'h0);
    ps2_bit(1'b1, pop_here, pop_exp);
    ps2_data = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0, 32'h0);
    ps2_data = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    probe       = 1'b0;
    bus.io_rdn  = 1'b1;
    bus.io_addr = 8'h00;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    tick();

    check_intr("reset_intr", 1'b0);
    cpu_read("reset_status", 8'h04, 32'h0);
    cpu_read("reset_data_empty", 8'h00, 32'h0);
    cpu_read("other_addr", 8'h08, 32'h0);

    // Single good frame
    send_byte(8'h1C, 1'b0, 1'b0, 32'h0);
    check_intr("intr_after_1c", 1'b1);
    cpu_read("data_1c", 8'h00, 32'h0000_001C);
    check_intr("intr_after_pop", 1'b0);
    cpu_read("status_after_1c", 8'h04, 32'h0);

    // Parity error
    send_byte(8'h1C, 1'b1, 1'b0, 32'h0);
    check_intr("intr_bad_parity", 1'b0);
    cpu_read("status_err", 8'h04, 32'h0000_0004);
    cpu_read("status_err_cleared", 8'h04, 32'h0);

    // Overflow with nine bytes
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0, 32'h0);
    check_intr("intr_full", 1'b1);
    cpu_read("status_full_ovf", 8'h04, 32'h0000_0083);
    for (int i = 1; i <= 8; i++) cpu_read($sformatf("drain_%0d", i), 8'h00, 32'(i));
    check_intr("intr_drained", 1'b0);
    cpu_read("status_drained", 8'h04, 32'h0);

    // Full FIFO: pop coincides with push of 0x5A
    for (int i = 8'h11; i <= 8'h18; i++) send_byte(8'(i), 1'b0, 1'b0, 32'h0);
    send_byte(8'h5A, 1'b0, 1'b1, 32'h0000_0011);
    cpu_read("status_after_coincide", 8'h04, 32'h0000_0081);
    for (int i = 8'h12; i <= 8'h18; i++) cpu_read($sformatf("drain2_%0h", i), 8'h00, 32'(i));
    cpu_read("drain2_5a", 8'h00, 32'h0000_005A);
    cpu_read("status_drained2", 8'h04, 32'h0);

    // Reset in the middle of a frame
    send_partial(8'hA5, 4);
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_intr("intr_after_midreset", 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 32'h0);
    cpu_read("status_after_33", 8'h04, 32'h0000_0011);
    cpu_read("data_33", 8'h00, 32'h0000_0033);
    cpu_read("status_after_33_pop", 8'h04, 32'h0);

`ifdef KBD_FRAME_TIMEOUT_EN
    send_partial(8'h0F, 3);
    repeat (TO + 20) tick();
    cpu_read("status_timeout", 8'h04, 32'h0000_0004);
    send_byte(8'h45, 1'b0, 1'b0, 32'h0);
    cpu_read("data_45", 8'h00, 32'h0000_0045);
    cpu_read("status_after_45", 8'h04, 32'h0);
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
